bigram_arbiter: RTL and testbench

Shares the single SDRAM word port ("big RAM") between three requesters: video refresh, CPU, and the RAM-disk image loader. It sits between the CPU bus, the RAM-disk page mapper output (3-bit page), and the SDRAM controller. One access is outstanding at a time. Fixed priority applies, with a starvation guard for the loader.

---
 rtl/bigram_arbiter_if.sv | 55 +++++
 rtl/bigram_arbiter.sv | 148 ++++++++++++++
 tb/tb_bigram_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bigram_arbiter_if.sv
// rtl/bigram_arbiter_if.sv - requester, SDRAM and owner signals shared by the big-RAM arbiter
interface bigram_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [2:0]  cpu_page;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;

    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_ack;
    logic [7:0]  vid_rdata;

    logic        ldr_req;
    logic [2:0]  ldr_page;
    logic [15:0] ldr_addr;
    logic [7:0]  ldr_wdata;
    logic        ldr_ack;

    logic        mem_req;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_done;

    logic [1:0]  owner;

    // Arbiter side: masters the SDRAM port and answers the three requesters.
    modport master (
        input  cpu_req, cpu_we, cpu_page, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  vid_req, vid_addr,
        output vid_ack, vid_rdata,
        input  ldr_req, ldr_page, ldr_addr, ldr_wdata,
        output ldr_ack,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_done,
        output owner
    );

    modport slave (
        output cpu_req, cpu_we, cpu_page, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output vid_req, vid_addr,
        input  vid_ack, vid_rdata,
        output ldr_req, ldr_page, ldr_addr, ldr_wdata,
        input  ldr_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_done,
        input  owner
    );
endinterface

// File: rtl/bigram_arbiter.sv
// rtl/bigram_arbiter.sv - video/CPU/loader arbiter for the SDRAM word port; loader path enabled by BIGRAM_LDR_EN
module bigram_arbiter #(
    parameter int STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             reset,
    bigram_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_VID  = 2'd1;
    localparam logic [1:0] OWN_CPU  = 2'd2;
    localparam logic [1:0] OWN_LDR  = 2'd3;

    state_t      state, state_nxt;
    logic [1:0]  owner_q;
    logic [1:0]  winner;
    logic        grant;
    logic [18:0] addr_q;
    logic [7:0]  wdata_q;
    logic        we_q;
    logic [7:0]  cpu_rdata_q;
    logic [7:0]  vid_rdata_q;
    logic        ldr_pending;
    logic        ldr_forced;

`ifdef BIGRAM_LDR_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt;

    assign ldr_pending = bus.ldr_req;
    assign ldr_forced  = bus.ldr_req && (starve_cnt == STARVE_TOP);

    // Counts CPU wins over a waiting loader; any cycle without a loader request forgets the history.
    always_ff @(posedge clk) begin
        if (reset || !bus.ldr_req) begin
            starve_cnt <= '0;
        end else if (grant && winner == OWN_LDR) begin
            starve_cnt <= '0;
        end else if (grant && winner == OWN_CPU && starve_cnt != STARVE_TOP) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

    assign bus.ldr_ack = (state == ACK) && (owner_q == OWN_LDR);
`else
    logic unused_ldr;
    assign unused_ldr  = ^{bus.ldr_req, bus.ldr_page, bus.ldr_addr, bus.ldr_wdata};
    assign ldr_pending = 1'b0;
    assign ldr_forced  = 1'b0;
    assign bus.ldr_ack = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        winner    = OWN_NONE;
        case (state)
            IDLE: begin
                if (bus.vid_req) begin
                    winner = OWN_VID;
                end else if (ldr_forced) begin
                    winner = OWN_LDR;
                end else if (bus.cpu_req) begin
                    winner = OWN_CPU;
                end else if (ldr_pending) begin
                    winner = OWN_LDR;
                end
                if (winner != OWN_NONE) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (bus.mem_done) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign grant = (state == IDLE) && (winner != OWN_NONE);

    // Winner's fields are captured once at grant so later requester-side changes cannot leak onto the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= OWN_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            if (grant) begin
                owner_q <= winner;
                case (winner)
                    OWN_VID: begin
                        addr_q  <= {3'd0, bus.vid_addr};
                        wdata_q <= '0;
                        we_q    <= 1'b0;
                    end
                    OWN_CPU: begin
                        addr_q  <= {bus.cpu_page, bus.cpu_addr};
                        wdata_q <= bus.cpu_wdata;
                        we_q    <= bus.cpu_we;
                    end
`ifdef BIGRAM_LDR_EN
                    OWN_LDR: begin
                        addr_q  <= {bus.ldr_page, bus.ldr_addr};
                        wdata_q <= bus.ldr_wdata;
                        we_q    <= 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            if (state == WAIT && bus.mem_done) begin
                if (owner_q == OWN_CPU && !we_q) begin
                    cpu_rdata_q <= bus.mem_rdata;
                end
                if (owner_q == OWN_VID) begin
                    vid_rdata_q <= bus.mem_rdata;
                end
            end
            if (state == ACK) begin
                owner_q <= OWN_NONE;
            end
        end
    end

    assign bus.mem_req   = (state == ISSUE) || (state == WAIT);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.owner     = owner_q;
    assign bus.cpu_ack   = (state == ACK) && (owner_q == OWN_CPU);
    assign bus.vid_ack   = (state == ACK) && (owner_q == OWN_VID);
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.vid_rdata = vid_rdata_q;
endmodule

// File: tb/tb_bigram_arbiter.sv
// tb/tb_bigram_arbiter.sv - directed and randomized bench for bigram_arbiter against a transaction-level model
module tb_bigram_arbiter;
    localparam int STARVE = 8;
`ifdef BIGRAM_LDR_EN
    localparam bit LDR_EN = 1'b1;
`else
    localparam bit LDR_EN = 1'b0;
`endif
    localparam int STARVE_LOOPS = LDR_EN ? STARVE + 1 : 25;

    logic clk = 1'b0;
    logic reset;

    bigram_arbiter_if bus ();

    bigram_arbiter #(.STARVE_MAX(STARVE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cpu_ack_seen = 0, vid_ack_seen = 0, ldr_ack_seen = 0, owner3_seen = 0;
    int exp_cpu_acks = 0, exp_vid_acks = 0, exp_ldr_acks = 0;
    logic [7:0] exp_cpu_rd = 8'h00;
    logic [7:0] exp_vid_rd = 8'h00;
    int starve_model = 0;

    always @(negedge clk) begin
        if (bus.cpu_ack) cpu_ack_seen <= cpu_ack_seen + 1;
        if (bus.vid_ack) vid_ack_seen <= vid_ack_seen + 1;
        if (bus.ldr_ack) ldr_ack_seen <= ldr_ack_seen + 1;
        if (bus.owner == 2'd3) owner3_seen <= owner3_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: video first, a starved loader next, then CPU, then loader.
    function automatic logic [1:0] pick(input logic v, input logic c, input logic l, input int cnt);
        if (v) return 2'd1;
        if (LDR_EN && l && cnt == STARVE) return 2'd3;
        if (c) return 2'd2;
        if (LDR_EN && l) return 2'd3;
        return 2'd0;
    endfunction

    task automatic fields_for(input logic [1:0] w, output logic [18:0] ea, output logic ewe, output logic [7:0] ewd);
        case (w)
            2'd1: begin ea = {3'b000, bus.vid_addr}; ewe = 1'b0; ewd = 8'h00; end
            2'd2: begin ea = {bus.cpu_page, bus.cpu_addr}; ewe = bus.cpu_we; ewd = bus.cpu_wdata; end
            default: begin ea = {bus.ldr_page, bus.ldr_addr}; ewe = 1'b1; ewd = bus.ldr_wdata; end
        endcase
    endtask

    task automatic scramble();
        bus.cpu_we    = 1'($urandom);
        bus.cpu_page  = 3'($urandom);
        bus.cpu_addr  = 16'($urandom);
        bus.cpu_wdata = 8'($urandom);
        bus.vid_addr  = 16'($urandom);
        bus.ldr_page  = 3'($urandom);
        bus.ldr_addr  = 16'($urandom);
        bus.ldr_wdata = 8'($urandom);
    endtask

    task automatic serve(input string tag, input logic [1:0] eo, input logic [18:0] ea, input logic ewe,
                         input logic [7:0] ewd, input int d, input logic [7:0] rd, input bit scr,
                         output int lat);
        int n = 0;
        while (bus.mem_req !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        check({tag, ":req"}, 32'(bus.mem_req), 32'd1);
        check({tag, ":owner"}, 32'(bus.owner), 32'(eo));
        check({tag, ":addr"}, 32'(bus.mem_addr), 32'(ea));
        check({tag, ":we"}, 32'(bus.mem_we), 32'(ewe));
        if (ewe) check({tag, ":wdata"}, 32'(bus.mem_wdata), 32'(ewd));
        for (int i = 0; i <= d; i++) begin
            @(negedge clk);
            check({tag, ":hold"}, 32'(bus.mem_req), 32'd1);
            if (scr) scramble();
        end
        bus.mem_rdata = rd;
        bus.mem_done  = 1'b1;
        @(negedge clk);
        bus.mem_done  = 1'b0;
        bus.mem_rdata = 8'($urandom);
        if (eo == 2'd2 && !ewe) exp_cpu_rd = rd;
        if (eo == 2'd1) exp_vid_rd = rd;
        if (eo == 2'd1) exp_vid_acks++;
        if (eo == 2'd2) exp_cpu_acks++;
        if (eo == 2'd3) exp_ldr_acks++;
        check({tag, ":vid_ack"}, 32'(bus.vid_ack), 32'(eo == 2'd1));
        check({tag, ":cpu_ack"}, 32'(bus.cpu_ack), 32'(eo == 2'd2));
        check({tag, ":ldr_ack"}, 32'(bus.ldr_ack), 32'(eo == 2'd3));
        check({tag, ":addr_kept"}, 32'(bus.mem_addr), 32'(ea));
        check({tag, ":cpu_rdata"}, 32'(bus.cpu_rdata), 32'(exp_cpu_rd));
        check({tag, ":vid_rdata"}, 32'(bus.vid_rdata), 32'(exp_vid_rd));
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, ":idle_req"}, 32'(bus.mem_req), 32'd0);
        check({tag, ":idle_owner"}, 32'(bus.owner), 32'd0);
        check({tag, ":idle_acks"}, 32'({bus.vid_ack, bus.cpu_ack, bus.ldr_ack}), 32'd0);
    endtask

    task automatic reroll(input logic [1:0] served);
        if (served == 2'd1 && $urandom_range(0, 3) != 0) bus.vid_req = 1'b0;
        if (served == 2'd2 && $urandom_range(0, 3) != 0) bus.cpu_req = 1'b0;
        if (served == 2'd3 && $urandom_range(0, 3) != 0) bus.ldr_req = 1'b0;
        if (!bus.vid_req && $urandom_range(0, 2) == 0) begin
            bus.vid_req  = 1'b1;
            bus.vid_addr = 16'($urandom);
        end
        if (!bus.cpu_req && $urandom_range(0, 1) == 0) begin
            bus.cpu_req   = 1'b1;
            bus.cpu_we    = 1'($urandom);
            bus.cpu_page  = 3'($urandom);
            bus.cpu_addr  = 16'($urandom);
            bus.cpu_wdata = 8'($urandom);
        end
        if (!bus.ldr_req && $urandom_range(0, 1) == 0) begin
            bus.ldr_req   = 1'b1;
            bus.ldr_page  = 3'($urandom);
            bus.ldr_addr  = 16'($urandom);
            bus.ldr_wdata = 8'($urandom);
        end
        if (!(bus.vid_req || bus.cpu_req || (LDR_EN && bus.ldr_req))) bus.cpu_req = 1'b1;
        if (!bus.ldr_req) starve_model = 0;
    endtask

    initial begin
        logic [1:0]  w;
        logic [18:0] ea;
        logic        ewe;
        logic [7:0]  ewd;
        int          lat;
        int          n;
        logic [1:0]  eo;

        reset = 1'b1;
        bus.cpu_req = 1'b0; bus.vid_req = 1'b0; bus.ldr_req = 1'b0;
        bus.mem_done = 1'b0; bus.mem_rdata = 8'h00;
        scramble();
        repeat (3) @(negedge clk);
        check("rst:mem_req", 32'(bus.mem_req), 32'd0);
        check("rst:mem_we", 32'(bus.mem_we), 32'd0);
        check("rst:acks", 32'({bus.vid_ack, bus.cpu_ack, bus.ldr_ack}), 32'd0);
        check("rst:owner", 32'(bus.owner), 32'd0);
        check("rst:mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst:mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst:cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        check("rst:vid_rdata", 32'(bus.vid_rdata), 32'd0);
        reset = 1'b0;

        // CPU read, page 3; address changes during WAIT must not reach the bus.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_page = 3'd3; bus.cpu_addr = 16'h1234;
        serve("cpu_rd", 2'd2, 19'h31234, 1'b0, 8'h00, 1, 8'h5A, 1'b1, lat);
        check("cpu_rd:latency", 32'(lat), 32'd1);
        bus.cpu_req = 1'b0;
        idle_check("cpu_rd");

        // Simultaneous video and CPU: video first.
        bus.vid_req = 1'b1; bus.vid_addr = 16'h8000;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_page = 3'd5; bus.cpu_addr = 16'h0101;
        serve("both_vid", 2'd1, 19'h08000, 1'b0, 8'h00, 0, 8'h3C, 1'b0, lat);
        bus.vid_req = 1'b0;
        idle_check("both_vid");
        serve("both_cpu", 2'd2, 19'h50101, 1'b0, 8'h00, 2, 8'hC3, 1'b0, lat);
        bus.cpu_req = 1'b0;
        idle_check("both_cpu");

        // Reset while a CPU write sits in WAIT.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_page = 3'd2; bus.cpu_addr = 16'h0042; bus.cpu_wdata = 8'h77;
        n = 0;
        while (bus.mem_req !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("rstwait:req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("rstwait:mem_req", 32'(bus.mem_req), 32'd0);
        check("rstwait:cpu_ack", 32'(bus.cpu_ack), 32'd0);
        check("rstwait:owner", 32'(bus.owner), 32'd0);
        check("rstwait:cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        check("rstwait:vid_rdata", 32'(bus.vid_rdata), 32'd0);
        reset = 1'b0;
        exp_cpu_rd = 8'h00; exp_vid_rd = 8'h00; starve_model = 0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_page = 3'd0; bus.cpu_addr = 16'h00FF;
        serve("after_rst", 2'd2, 19'h000FF, 1'b0, 8'h00, 0, 8'h96, 1'b0, lat);
        bus.cpu_req = 1'b0;
        idle_check("after_rst");

        // Spurious mem_done with nothing in flight.
        bus.mem_done = 1'b1;
        @(negedge clk);
        bus.mem_done = 1'b0;
        check("spur:acks", 32'({bus.vid_ack, bus.cpu_ack, bus.ldr_ack}), 32'd0);
        check("spur:req", 32'(bus.mem_req), 32'd0);
        idle_check("spur");

        // CPU held with the loader waiting.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_page = 3'd4; bus.cpu_addr = 16'h0200;
        bus.ldr_req = 1'b1; bus.ldr_page = 3'd1; bus.ldr_addr = 16'h0010; bus.ldr_wdata = 8'hA5;
        for (int k = 0; k < STARVE_LOOPS; k++) begin
            eo = (LDR_EN && k == STARVE) ? 2'd3 : 2'd2;
            if (eo == 2'd3) serve("starve_ldr", eo, 19'h10010, 1'b1, 8'hA5, 0, 8'h00, 1'b0, lat);
            else serve("starve_cpu", eo, 19'h40200, 1'b0, 8'h00, 0, 8'(k), 1'b0, lat);
`ifdef BIGRAM_LDR_EN
            if (k == STARVE - 1) check("starve:top", 32'(dut.starve_cnt), 32'(STARVE));
            if (k == STARVE) check("starve:clear", 32'(dut.starve_cnt), 32'd0);
`endif
            idle_check("starve");
        end
        bus.cpu_req = 1'b0;
        bus.ldr_req = 1'b0;
        starve_model = 0;
        idle_check("starve_end");

        // Randomized traffic against the reference model.
        reroll(2'd0);
        for (int k = 0; k < 120; k++) begin
            w = pick(bus.vid_req, bus.cpu_req, bus.ldr_req, starve_model);
            fields_for(w, ea, ewe, ewd);
            serve("rand", w, ea, ewe, ewd, int'($urandom_range(0, 3)), 8'($urandom), 1'b1, lat);
            if (w == 2'd2 && bus.ldr_req) starve_model = (starve_model < STARVE) ? starve_model + 1 : starve_model;
            if (w == 2'd3) starve_model = 0;
            reroll(w);
            idle_check("rand");
        end
        bus.cpu_req = 1'b0; bus.vid_req = 1'b0; bus.ldr_req = 1'b0;
        repeat (4) @(negedge clk);

        check("total:cpu_acks", 32'(cpu_ack_seen), 32'(exp_cpu_acks));
        check("total:vid_acks", 32'(vid_ack_seen), 32'(exp_vid_acks));
        check("total:ldr_acks", 32'(ldr_ack_seen), 32'(exp_ldr_acks));
        check("total:owner3", 32'(owner3_seen != 0), 32'(LDR_EN));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
